decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: one output register plus a skid entry.
// Optional `DECODE_ILLEGAL_TRAP_EN adds an illegal-opcode output.
module decode_stage #(
    parameter int OPW    = 5,
    parameter int RW     = 5,
    parameter int LW     = 32,
    parameter int MAX_OP = 5'h10,
    localparam int IW    = OPW + 2 + 2*RW + LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OPW-1:0] op,
    output logic [1:0]    md,
    output logic [LW-1:0] src1,
    output logic [LW-1:0] dst,
    output logic [LW-1:0] literal_src,
    output logic          load,
    output logic          ramload,
    output logic          regread,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic          illegal,
`endif
    output logic [15:0]   dec_count
);

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [1:0]     md;
        logic [LW-1:0]  src1;
        logic [LW-1:0]  dst;
        logic [LW-1:0]  lit;
        logic           load;
        logic           ramload;
        logic           regread;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic           illegal;
`endif
    } dec_t;

    if (MAX_OP >= (1 << OPW)) begin : g_bad_max_op
        $error("MAX_OP exceeds opcode range");
    end

    logic [OPW-1:0] w_op;
    logic [1:0]     w_md;
    logic [RW-1:0]  w_src;
    logic [RW-1:0]  w_dst;
    logic [LW-1:0]  w_lit;
    logic           w_is_st;
    logic           w_is_ld;
    dec_t           w_dec;

    assign w_op  = instr[IW-1 -: OPW];
    assign w_md  = instr[LW+2*RW +: 2];
    assign w_src = instr[LW+RW +: RW];
    assign w_dst = instr[LW +: RW];
    assign w_lit = instr[LW-1:0];

    assign w_is_st = (w_op == OPW'(2));
    assign w_is_ld = (w_op == OPW'(1)) && (w_md == 2'b01);

    always_comb begin
        w_dec    = '0;
        w_dec.op = w_op;
        w_dec.md = w_md;
        unique case (1'b1)
            w_is_st: begin
                w_dec.src1 = LW'(w_src);
                w_dec.dst  = w_lit;
                w_dec.lit  = LW'(w_dst);
                w_dec.load = 1'b1;
            end
            w_is_ld: begin
                w_dec.src1    = w_lit;
                w_dec.dst     = LW'(w_dst);
                w_dec.lit     = LW'(w_src);
                w_dec.ramload = 1'b1;
            end
            default: begin
                w_dec.src1    = LW'(w_src);
                w_dec.dst     = LW'(w_dst);
                w_dec.lit     = w_lit;
                w_dec.regread = 1'b1;
            end
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (int'(w_op) > MAX_OP) begin
            w_dec.illegal = 1'b1;
            w_dec.load    = 1'b0;
            w_dec.ramload = 1'b0;
            w_dec.regread = 1'b0;
        end
`endif
    end

    dec_t        r_out;
    dec_t        r_skid;
    logic        r_out_valid;
    logic        r_skid_valid;
    logic        r_in_ready;
    logic [15:0] r_count;
    logic        w_accept;
    logic        w_xfer;

    assign w_accept = in_valid && r_in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_count      <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_xfer)
                r_count <= r_count + 16'd1;
            if (!r_out_valid || out_ready) begin
                // Skid is only ever full while the output is full.
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (w_accept) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
                r_in_ready   <= 1'b0;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign op          = r_out.op;
    assign md          = r_out.md;
    assign src1        = r_out.src1;
    assign dst         = r_out.dst;
    assign literal_src = r_out.lit;
    assign load        = r_out.load;
    assign ramload     = r_out.ramload;
    assign regread     = r_out.regread;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal     = r_out.illegal;
`endif
    assign dec_count   = r_count;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Inputs change and outputs are sampled on the falling edge.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [48:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  op;
    logic [1:0]  md;
    logic [31:0] src1;
    logic [31:0] dst;
    logic [31:0] literal_src;
    logic        load;
    logic        ramload;
    logic        regread;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic [15:0] dec_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op          (op),
        .md          (md),
        .src1        (src1),
        .dst         (dst),
        .literal_src (literal_src),
        .load        (load),
        .ramload     (ramload),
        .regread     (regread),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal     (illegal),
`endif
        .dec_count   (dec_count)
    );

    function automatic logic [48:0] mk(input logic [4:0] o,
                                       input logic [1:0] m,
                                       input logic [4:0] s,
                                       input logic [4:0] d,
                                       input logic [31:0] l);
        return {o, m, s, d, l};
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; instr = '0;
        tick(); tick();
        chk("rst_ovalid", out_valid, 0);
        chk("rst_iready", in_ready, 1);
        chk("rst_cnt", dec_count, 0);
        chk("rst_op", op, 0);
        rst = 1'b0;

        // ST
        in_valid = 1'b1; out_ready = 1'b1;
        instr = mk(5'd2, 2'b00, 5'd3, 5'd7, 32'h100);
        tick();
        in_valid = 1'b0;
        chk("st_ovalid", out_valid, 1);
        chk("st_op", op, 2);
        chk("st_src1", src1, 3);
        chk("st_dst", dst, 32'h100);
        chk("st_lit", literal_src, 7);
        chk("st_flags", {load, ramload, regread}, 3'b100);
        tick();
        chk("st_cnt", dec_count, 1);
        chk("st_drain", out_valid, 0);

        // LD direct then LD with md=00, back to back
        in_valid = 1'b1;
        instr = mk(5'd1, 2'b01, 5'd4, 5'd9, 32'h2000);
        tick();
        chk("ld_src1", src1, 32'h2000);
        chk("ld_dst", dst, 9);
        chk("ld_lit", literal_src, 4);
        chk("ld_md", md, 2'b01);
        chk("ld_flags", {load, ramload, regread}, 3'b010);
        instr = mk(5'd1, 2'b00, 5'd4, 5'd9, 32'h2000);
        tick();
        in_valid = 1'b0;
        chk("ldr_src1", src1, 4);
        chk("ldr_dst", dst, 9);
        chk("ldr_lit", literal_src, 32'h2000);
        chk("ldr_flags", {load, ramload, regread}, 3'b001);
        tick();
        chk("ld_cnt", dec_count, 3);

        // Backpressure: A, B, C with out_ready low
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        instr = mk(5'd3, 2'b10, 5'd1, 5'd2, 32'hA);
        tick();
        chk("bp_a_ovalid", out_valid, 1);
        chk("bp_a_ready", in_ready, 1);
        instr = mk(5'd3, 2'b10, 5'd1, 5'd2, 32'hB);
        tick();
        chk("bp_b_ready", in_ready, 0);
        chk("bp_hold_a", literal_src, 32'hA);
        instr = mk(5'd3, 2'b10, 5'd1, 5'd2, 32'hC);
        tick();
        chk("bp_c_ready", in_ready, 0);
        chk("bp_hold_a2", literal_src, 32'hA);
        chk("bp_hold_cnt", dec_count, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_b_out", literal_src, 32'hB);
        chk("bp_cnt1", dec_count, 1);
        chk("bp_ready1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_out", literal_src, 32'hC);
        chk("bp_cnt2", dec_count, 2);
        tick();
        chk("bp_cnt3", dec_count, 3);
        chk("bp_empty", out_valid, 0);

        // Flush with two entries buffered
        out_ready = 1'b0; in_valid = 1'b1;
        instr = mk(5'd4, 2'b00, 5'd1, 5'd1, 32'hD);
        tick();
        instr = mk(5'd4, 2'b00, 5'd1, 5'd1, 32'hE);
        tick();
        chk("fl_full", {out_valid, in_ready}, 2'b10);
        flush = 1'b1; out_ready = 1'b1;
        instr = mk(5'd4, 2'b00, 5'd1, 5'd1, 32'hF);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_ovalid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_cnt", dec_count, 3);
        tick();
        chk("fl_discard", out_valid, 0);

        // Reset with skid full
        out_ready = 1'b0; in_valid = 1'b1;
        instr = mk(5'd2, 2'b00, 5'd3, 5'd7, 32'h55);
        tick(); tick();
        chk("rs_full", in_ready, 0);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rs_ovalid", out_valid, 0);
        chk("rs_ready", in_ready, 1);
        chk("rs_cnt", dec_count, 0);
        chk("rs_data", {op, md, src1, dst, literal_src}, 0);
        chk("rs_flags", {load, ramload, regread}, 3'b000);

        // Opcode above MAX_OP
        in_valid = 1'b1;
        instr = mk(5'h1F, 2'b00, 5'd1, 5'd2, 32'h3);
        tick();
        chk("hi_op", op, 5'h1F);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("ill_set", illegal, 1);
        chk("ill_flags", {load, ramload, regread}, 3'b000);
`else
        chk("hi_flags", {load, ramload, regread}, 3'b001);
`endif
        instr = mk(5'h10, 2'b00, 5'd1, 5'd2, 32'h3);
        tick();
        in_valid = 1'b0;
        chk("max_flags", {load, ramload, regread}, 3'b001);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("ill_clr", illegal, 0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
